// File: rtl/debounce_bank.sv
`default_nettype none
// ============================================================================
// Module      : debounce_bank
// Description : Multi-channel button conditioner: sync, tick-sampled debounce,
//               press/release edges and long-press/auto-repeat hold pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_bank #(
    parameter int CHANNELS      = 4,
    parameter int CLK_HZ        = 50_000_000,
    parameter int SAMPLE_HZ     = 1000,
    parameter int STABLE_CNT    = 8,
    parameter int HOLD_CNT      = 500,
    parameter int REPEAT_CNT    = 100,
    parameter int ACTIVE_LOW_IN = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] btn_in,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] press,
    output logic [CHANNELS-1:0] released,
    output logic [CHANNELS-1:0] hold
);

    localparam int c_DIV    = CLK_HZ / SAMPLE_HZ;
    localparam int c_DIV_W  = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam int c_CNT_W  = $clog2(STABLE_CNT + 1);
    localparam int c_HMAX   = (HOLD_CNT > REPEAT_CNT) ? HOLD_CNT : REPEAT_CNT;
    localparam int c_HCNT_W = $clog2(c_HMAX + 1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ARMED  = 2'd1;
    localparam logic [1:0] c_REPEAT = 2'd2;

    logic [CHANNELS-1:0] w_raw;
    logic [CHANNELS-1:0] r_sync1;
    logic [CHANNELS-1:0] r_sync2;
    logic [c_DIV_W-1:0]  r_div;
    logic                w_tick;

    // Inversion happens before the synchroniser so "pressed" is always 1 inside.
    assign w_raw = (ACTIVE_LOW_IN != 0) ? ~btn_in : btn_in;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_tick = (r_div == c_DIV_W'(c_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    generate
        for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
            logic [c_CNT_W-1:0]  r_cnt;
            logic                r_level;
            logic                r_press;
            logic                r_rel;
            logic                r_hold;
            logic                w_diff;
            logic                w_flip;
            logic                w_rise;
            logic                w_fall;
            logic [1:0]          r_state;
            logic [1:0]          w_state_nxt;
            logic [c_HCNT_W-1:0] r_hcnt;
            logic [c_HCNT_W-1:0] w_hcnt_nxt;
            logic                w_hold_thr;
            logic                w_rep_thr;
            logic                w_hold_pulse;

            assign w_diff = r_sync2[g] ^ r_level;
            assign w_flip = w_tick && w_diff && ((32'(r_cnt) + 1) == STABLE_CNT);
            assign w_rise = w_flip && !r_level;
            assign w_fall = w_flip && r_level;

            // Edge pulses are registered alongside the level so they align with it.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_cnt   <= '0;
                    r_level <= 1'b0;
                    r_press <= 1'b0;
                    r_rel   <= 1'b0;
                end else begin
                    r_press <= w_rise;
                    r_rel   <= w_fall;
                    if (w_tick) begin
                        if (!w_diff || w_flip) begin
                            r_cnt <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    if (w_flip) begin
                        r_level <= ~r_level;
                    end
                end
            end

            assign w_hold_thr = ((32'(r_hcnt) + 1) == HOLD_CNT);
            assign w_rep_thr  = ((32'(r_hcnt) + 1) == REPEAT_CNT);

            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_state <= c_IDLE;
                    r_hcnt  <= '0;
                    r_hold  <= 1'b0;
                end else begin
                    r_state <= w_state_nxt;
                    r_hcnt  <= w_hcnt_nxt;
                    r_hold  <= w_hold_pulse;
                end
            end

            // A falling level overrides everything, so release beats a hold threshold.
            always_comb begin
                w_state_nxt = r_state;
                w_hcnt_nxt  = r_hcnt;
                if (w_fall) begin
                    w_state_nxt = c_IDLE;
                    w_hcnt_nxt  = '0;
                end else begin
                    case (r_state)
                        c_IDLE: begin
                            if (w_rise) begin
                                w_state_nxt = c_ARMED;
                                w_hcnt_nxt  = '0;
                            end
                        end
                        c_ARMED: begin
                            if (w_tick) begin
                                if (w_hold_thr) begin
                                    w_state_nxt = c_REPEAT;
                                    w_hcnt_nxt  = '0;
                                end else begin
                                    w_hcnt_nxt = r_hcnt + 1'b1;
                                end
                            end
                        end
                        c_REPEAT: begin
                            if (w_tick && (REPEAT_CNT != 0)) begin
                                if (w_rep_thr) begin
                                    w_hcnt_nxt = '0;
                                end else begin
                                    w_hcnt_nxt = r_hcnt + 1'b1;
                                end
                            end
                        end
                        default: begin
                            w_state_nxt = c_IDLE;
                            w_hcnt_nxt  = '0;
                        end
                    endcase
                end
            end

            always_comb begin
                w_hold_pulse = 1'b0;
                if (w_tick && !w_fall) begin
                    case (r_state)
                        c_ARMED:  w_hold_pulse = w_hold_thr;
                        c_REPEAT: w_hold_pulse = (REPEAT_CNT != 0) && w_rep_thr;
                        default:  w_hold_pulse = 1'b0;
                    endcase
                end
            end

            assign level[g]    = r_level;
            assign press[g]    = r_press;
            assign released[g] = r_rel;
            assign hold[g]     = r_hold;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_debounce_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_debounce_bank
// Description : Scoreboard bench for debounce_bank with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_debounce_bank;

    logic       clk    = 1'b0;
    logic       rst    = 1'b0;
    logic [3:0] btn_in = 4'b0000;
    logic [3:0] level;
    logic [3:0] press;
    logic [3:0] released;
    logic [3:0] hold;

    int cyc   = 0;
    int base  = 0;
    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] cyc;
        logic [3:0]  lv;
        logic [3:0]  pr;
        logic [3:0]  rl;
        logic [3:0]  hd;
    } ev_t;

    ev_t exp_q[$];
    ev_t m_got;
    ev_t m_want;

    debounce_bank #(
        .CHANNELS(4), .CLK_HZ(1000), .SAMPLE_HZ(100),
        .STABLE_CNT(4), .HOLD_CNT(20), .REPEAT_CNT(5), .ACTIVE_LOW_IN(0)
    ) dut (
        .clk(clk), .rst(rst), .btn_in(btn_in),
        .level(level), .press(press), .released(released), .hold(hold)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Event k is the k-th clock edge after reset release (edge 0 samples rst=1).
    task automatic expect_ev(input int k, input logic [3:0] lv, input logic [3:0] pr,
                             input logic [3:0] rl, input logic [3:0] hd);
        ev_t e;
        e.cyc = 32'(base + k);
        e.lv  = lv;
        e.pr  = pr;
        e.rl  = rl;
        e.hd  = hd;
        exp_q.push_back(e);
    endtask

    task automatic go(input int j);
        while (cyc < base + j - 1) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if ((press | released | hold) != 4'b0000) begin
            m_got = {32'(cyc), level, press, released, hold};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event: got cyc=%0d lv=%b pr=%b rl=%b hd=%b required none",
                         m_got.cyc, m_got.lv, m_got.pr, m_got.rl, m_got.hd);
            end else begin
                m_want = exp_q.pop_front();
                if (m_got !== m_want) begin
                    bad++;
                    $display("FAIL event: got cyc=%0d lv=%b pr=%b rl=%b hd=%b required cyc=%0d lv=%b pr=%b rl=%b hd=%b",
                             m_got.cyc, m_got.lv, m_got.pr, m_got.rl, m_got.hd,
                             m_want.cyc, m_want.lv, m_want.pr, m_want.rl, m_want.hd);
                end
            end
        end
    end

    initial begin
        // Reset with all buttons held.
        btn_in = 4'b1111;
        rst    = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("reset_outputs", {level, press, released, hold}, 16'h0000);
        end
        rst  = 1'b1;
        base = cyc + 1;
        expect_ev(39, 4'b1111, 4'b1111, 4'b0000, 4'b0000);
        go(39);
        chk("level_before_4th_tick", {12'h000, level}, 16'h0000);
        go(41);
        chk("level_after_4th_tick", {12'h000, level}, 16'h000f);
        go(50);
        btn_in = 4'b0000;
        expect_ev(89, 4'b0000, 4'b0000, 4'b1111, 4'b0000);

        // Clean press and release on ch0.
        go(100);
        btn_in = 4'b0001;
        expect_ev(139, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
        go(150);
        btn_in = 4'b0000;
        expect_ev(189, 4'b0000, 4'b0000, 4'b0001, 4'b0000);

        // Bounce on ch1: 25-cycle stretches never reach 4 stable samples.
        for (int i = 0; i < 12; i++) begin
            go(200 + 25 * i);
            btn_in[1] = ((i % 2) == 0);
        end
        go(490);
        chk("bounce_rejected", {12'h000, level}, 16'h0000);
        go(500);
        btn_in[1] = 1'b1;
        expect_ev(539, 4'b0010, 4'b0010, 4'b0000, 4'b0000);
        go(560);
        btn_in[1] = 1'b0;
        expect_ev(599, 4'b0000, 4'b0000, 4'b0010, 4'b0000);

        // Long press on ch2; release lands on the 40th tick, where a repeat would fire.
        go(600);
        btn_in[2] = 1'b1;
        expect_ev(639, 4'b0100, 4'b0100, 4'b0000, 4'b0000);
        expect_ev(839, 4'b0100, 4'b0000, 4'b0000, 4'b0100);
        expect_ev(889, 4'b0100, 4'b0000, 4'b0000, 4'b0100);
        expect_ev(939, 4'b0100, 4'b0000, 4'b0000, 4'b0100);
        expect_ev(989, 4'b0100, 4'b0000, 4'b0000, 4'b0100);
        go(1000);
        btn_in[2] = 1'b0;
        expect_ev(1039, 4'b0000, 4'b0000, 4'b0100, 4'b0000);

        // Simultaneous ch0 press and ch3 release.
        go(1100);
        btn_in[3] = 1'b1;
        expect_ev(1139, 4'b1000, 4'b1000, 4'b0000, 4'b0000);
        go(1200);
        btn_in = 4'b0001;
        expect_ev(1239, 4'b0001, 4'b0001, 4'b1000, 4'b0000);
        go(1260);
        btn_in[0] = 1'b0;
        expect_ev(1299, 4'b0000, 4'b0000, 4'b0001, 4'b0000);

        // Reset while ch2 sits in REPEAT.
        go(1320);
        btn_in[2] = 1'b1;
        expect_ev(1359, 4'b0100, 4'b0100, 4'b0000, 4'b0000);
        expect_ev(1559, 4'b0100, 4'b0000, 4'b0000, 4'b0100);
        go(1600);
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("midhold_reset_outputs", {level, press, released, hold}, 16'h0000);
        end
        rst  = 1'b1;
        base = cyc + 1;
        expect_ev(39, 4'b0100, 4'b0100, 4'b0000, 4'b0000);
        go(30);
        chk("level_restarts_after_reset", {12'h000, level}, 16'h0000);
        go(50);
        btn_in[2] = 1'b0;
        expect_ev(89, 4'b0000, 4'b0000, 4'b0100, 4'b0000);

        go(120);
        chk("pending_events", 16'(exp_q.size()), 16'h0000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
